seg7_scan_driver: RTL and testbench

Parametrised multi-digit, time-multiplexed seven-segment display driver; next generation of the team's single-digit hex-to-segment decoder.
- Holds a double-buffered NUM_DIGITS-nibble value and scans one digit at a time at a programmable rate.
- Adds leading-zero blanking, per-digit decimal points, a ghost-guard cycle and selectable output polarities.
- Sits between a control/datapath block and the board's segment and digit-select pins.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_hex_lut.sv | 11 +
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: the team glyph table,
// the "all segments dark" pattern and the digit-index width helper.
package seg7_pkg;

  // Glyphs for hex 0..F, bit order {g,f,e,d,c,b,a}; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the control/datapath side and the display driver.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  // load is a one-cycle strobe sampled on every rising clk edge; there is no
  // ready/backpressure, so the driver accepts value_in/dp_in whenever load = 1.
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport master (
    output load, value_in, dp_in, blank_in,
    input  seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  load, value_in, dp_in, blank_in,
    output seg, dp, dig_sel, frame_done
  );
endinterface

// File: rtl/seg7_hex_lut.sv
// Combinational nibble to seven-segment glyph decoder.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPHS[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with double-buffered value,
// leading-zero blanking, per-digit decimal points and a ghost-guard cycle.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic DP_RST = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] DIG_RST = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic                    r_frame_done;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig;

  logic                    w_tick;
  logic                    w_last;
  logic                    w_wrap;
  logic [IW-1:0]           w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_disp_val_nxt;
  logic [NUM_DIGITS-1:0]   w_disp_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [3:0]              w_nib;
  logic                    w_dp_cur;
  logic                    w_lz_cur;
  logic [6:0]              w_glyph;
  logic [6:0]              w_seg_pre;

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
  assign w_last = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_wrap = w_tick & w_last;

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_tick) begin
      w_idx_nxt = w_last ? '0 : r_idx + 1'b1;
    end
  end

  // Display only changes on the wrap tick, so a frame never tears. A load on
  // that same cycle bypasses the pending buffer and lands in the new frame.
  always_comb begin
    w_disp_val_nxt = r_disp_val;
    w_disp_dp_nxt  = r_disp_dp;
    if (w_wrap) begin
      w_disp_val_nxt = bus.load ? bus.value_in : r_pend_val;
      w_disp_dp_nxt  = bus.load ? bus.dp_in    : r_pend_dp;
    end
  end

  // Digit i (i > 0) is a leading zero when nibbles i..N-1 are all zero.
  always_comb begin : p_lz
    logic w_zero;
    w_zero = 1'b1;
    w_lz   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero = w_zero & (w_disp_val_nxt[i*4 +: 4] == 4'h0);
      w_lz[i] = (LZ_BLANK != 0) && (i != 0) && w_zero;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp_cur = 1'b0;
    w_lz_cur = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IW'(i)) begin
        w_nib       = w_disp_val_nxt[i*4 +: 4];
        w_dp_cur    = w_disp_dp_nxt[i];
        w_lz_cur    = w_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seg7_hex_lut u_lut (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  assign w_seg_pre = w_lz_cur ? SEG_OFF : w_glyph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_frame_done <= 1'b0;
      r_seg        <= SEG_RST;
      r_dp         <= DP_RST;
      r_dig        <= DIG_RST;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_idx        <= w_idx_nxt;
      if (bus.load) begin
        r_pend_val <= bus.value_in;
        r_pend_dp  <= bus.dp_in;
      end
      r_disp_val   <= w_disp_val_nxt;
      r_disp_dp    <= w_disp_dp_nxt;
      r_frame_done <= w_wrap;
      r_seg        <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_pre : w_seg_pre;
      r_dp         <= w_dp_cur ^ DP_RST;
      // Ghost guard: all digits dark for the first cycle of each digit period
      // while segments settle onto the new glyph.
      r_dig        <= ((w_tick || bus.blank_in) ? '0 : w_onehot) ^ DIG_RST;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.dig_sel    = r_dig;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances cover plain scanning,
// leading-zero blanking and inverted output polarities.
module tb_seg7_scan_driver;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dpv;
    logic [3:0][6:0] g;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t av[5];
  vec_t bv[5];
  vec_t v1s;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) if_a ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) if_b ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) if_c ();

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(0),
                     .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1),
                     .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
    u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks and output readers
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int s, input logic ld, input logic [15:0] v,
                       input logic [3:0] d, input logic b);
    case (s)
      0: begin if_a.load = ld; if_a.value_in = v; if_a.dp_in = d; if_a.blank_in = b; end
      1: begin if_b.load = ld; if_b.value_in = v; if_b.dp_in = d; if_b.blank_in = b; end
      default: begin if_c.load = ld; if_c.value_in = v; if_c.dp_in = d; if_c.blank_in = b; end
    endcase
  endtask

  function automatic logic [6:0] rd_seg(input int s);
    case (s)
      0: return if_a.seg;
      1: return if_b.seg;
      default: return if_c.seg;
    endcase
  endfunction

  function automatic logic rd_dp(input int s);
    case (s)
      0: return if_a.dp;
      1: return if_b.dp;
      default: return if_c.dp;
    endcase
  endfunction

  function automatic logic [3:0] rd_dig(input int s);
    case (s)
      0: return if_a.dig_sel;
      1: return if_b.dig_sel;
      default: return if_c.dig_sel;
    endcase
  endfunction

  function automatic logic rd_fd(input int s);
    case (s)
      0: return if_a.frame_done;
      1: return if_b.frame_done;
      default: return if_c.frame_done;
    endcase
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_frame(input int s);
    int n;
    n = 0;
    while (rd_fd(s) !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk($sformatf("frame_wait_dut%0d", s), {31'd0, rd_fd(s)}, 32'd1);
  endtask

  // Entered at the first cycle of a frame; leaves at the first cycle of the next.
  task automatic check_frame(input int s, input vec_t v, input logic blanked,
                             input logic nxt_load, input vec_t nv, input logic nxt_blank);
    for (int k = 0; k < 16; k++) begin
      int d;
      int j;
      logic [3:0] exp_sel;
      d = k / 4;
      j = k % 4;
      exp_sel = (blanked || j == 0) ? 4'b0000 : (4'b0001 << d);
      if (!blanked) begin
        chk($sformatf("seg_dut%0d_v%h_k%0d", s, v.val, k), rd_seg(s), v.g[d]);
        chk($sformatf("dp_dut%0d_v%h_k%0d", s, v.val, k), rd_dp(s), v.dpv[d]);
      end
      chk($sformatf("dig_dut%0d_v%h_k%0d", s, v.val, k), rd_dig(s), exp_sel);
      chk($sformatf("fd_dut%0d_v%h_k%0d", s, v.val, k), rd_fd(s), (k == 0));
      if (k == 15) drive(s, nxt_load, nv.val, nv.dpv, nxt_blank);
      step();
      if (k == 15) drive(s, 1'b0, nv.val, nv.dpv, nxt_blank);
    end
    chk($sformatf("fd_period_dut%0d_v%h", s, v.val), rd_fd(s), 1'b1);
  endtask

  initial begin
    int c;
    n_checks = 0;
    n_fail   = 0;

    av[0] = '{16'h12AF, 4'b0100, {7'h06, 7'h5B, 7'h77, 7'h71}};
    av[1] = '{16'h0000, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    av[2] = '{16'h8E3C, 4'b1001, {7'h7F, 7'h79, 7'h4F, 7'h39}};
    av[3] = '{16'h7654, 4'b0010, {7'h07, 7'h7D, 7'h6D, 7'h66}};
    av[4] = '{16'h9BD0, 4'b1111, {7'h67, 7'h7C, 7'h5E, 7'h3F}};
    bv[0] = '{16'h0005, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h6D}};
    bv[1] = '{16'h0000, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3F}};
    bv[2] = '{16'h0300, 4'b0000, {7'h00, 7'h4F, 7'h3F, 7'h3F}};
    bv[3] = '{16'h1000, 4'b0000, {7'h06, 7'h3F, 7'h3F, 7'h3F}};
    bv[4] = '{16'h0A0B, 4'b1000, {7'h00, 7'h77, 7'h3F, 7'h7C}};
    v1s   = '{16'h1111, 4'b0000, {7'h06, 7'h06, 7'h06, 7'h06}};

    for (int s = 0; s < 3; s++) drive(s, 1'b0, 16'h0, 4'h0, 1'b0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_a_seg", rd_seg(0), 7'h00);
    chk("rst_a_dp",  rd_dp(0),  1'b0);
    chk("rst_a_dig", rd_dig(0), 4'b0000);
    chk("rst_a_fd",  rd_fd(0),  1'b0);
    chk("rst_c_seg", rd_seg(2), 7'h7F);
    chk("rst_c_dp",  rd_dp(2),  1'b1);
    chk("rst_c_dig", rd_dig(2), 4'b1111);
    chk("rst_c_fd",  rd_fd(2),  1'b0);
    step();
    step();
    rst = 1'b0;

    // scan sequence, with every later value loaded on the wrap-tick cycle
    drive(0, 1'b1, av[0].val, av[0].dpv, 1'b0);
    step();
    drive(0, 1'b0, av[0].val, av[0].dpv, 1'b0);
    wait_frame(0);
    for (int i = 0; i < 5; i++) begin
      check_frame(0, av[i], 1'b0, (i < 4), av[(i + 1) % 5], 1'b0);
    end

    // mid-frame load must not disturb the frame being shown
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("dbuf_seg_k%0d", k), rd_seg(0), av[4].g[k / 4]);
      if (k == 5) drive(0, 1'b1, 16'h1111, 4'h0, 1'b0);
      step();
      if (k == 5) drive(0, 1'b0, 16'h1111, 4'h0, 1'b0);
    end
    check_frame(0, v1s, 1'b0, 1'b0, v1s, 1'b1);

    // blank_in held for one full frame, then released
    check_frame(0, v1s, 1'b1, 1'b0, v1s, 1'b0);
    check_frame(0, v1s, 1'b0, 1'b0, v1s, 1'b0);

    // asynchronous reset in the middle of digit 1
    for (int k = 0; k < 5; k++) step();
    chk("pre_rst_dig", rd_dig(0), 4'b0010);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_seg", rd_seg(0), 7'h00);
    chk("mid_rst_dp",  rd_dp(0),  1'b0);
    chk("mid_rst_dig", rd_dig(0), 4'b0000);
    chk("mid_rst_fd",  rd_fd(0),  1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    c = 0;
    do begin
      step();
      c++;
      if (c == 1) begin
        chk("post_rst_seg", rd_seg(0), 7'h3F);
        chk("post_rst_dig", rd_dig(0), 4'b0001);
      end
    end while (rd_fd(0) !== 1'b1 && c < 40);
    chk("post_rst_first_wrap_cycles", c, 16);
    check_frame(0, av[1], 1'b0, 1'b0, av[1], 1'b0);

    // leading-zero blanking
    drive(1, 1'b1, bv[0].val, bv[0].dpv, 1'b0);
    step();
    drive(1, 1'b0, bv[0].val, bv[0].dpv, 1'b0);
    wait_frame(1);
    for (int i = 0; i < 5; i++) begin
      check_frame(1, bv[i], 1'b0, (i < 4), bv[(i + 1) % 5], 1'b0);
    end

    // inverted polarities: digit 0 shows 8, digit 1 is a blanked leading zero
    drive(2, 1'b1, 16'h0008, 4'b0001, 1'b0);
    step();
    drive(2, 1'b0, 16'h0008, 4'b0001, 1'b0);
    wait_frame(2);
    chk("pol_k0_seg", rd_seg(2), 7'h00);
    chk("pol_k0_dp",  rd_dp(2),  1'b0);
    chk("pol_k0_dig", rd_dig(2), 4'b1111);
    step();
    chk("pol_k1_seg", rd_seg(2), 7'h00);
    chk("pol_k1_dig", rd_dig(2), 4'b1110);
    chk("pol_k1_fd",  rd_fd(2),  1'b0);
    step();
    step();
    step();
    chk("pol_k4_seg", rd_seg(2), 7'h7F);
    chk("pol_k4_dp",  rd_dp(2),  1'b1);
    chk("pol_k4_dig", rd_dig(2), 4'b1111);
    step();
    chk("pol_k5_dig", rd_dig(2), 4'b1101);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
